// File: rtl/irom_loader_if.sv
// Byte-stream input and IROM/CPU-control outputs of the boot loader.
// slave is the loader side; master is the side that drives bytes and observes writes.
interface irom_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        irom_we;
  logic [31:0] irom_wadr;
  logic [31:0] irom_wdata;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_err;

  modport slave (
    input  rx_valid, rx_data,
    output irom_we, irom_wadr, irom_wdata, cpu_rst_n, load_done, load_err
  );

  modport master (
    output rx_valid, rx_data,
    input  irom_we, irom_wadr, irom_wdata, cpu_rst_n, load_done, load_err
  );
endinterface

// File: rtl/irom_loader.sv
// Boot loader: unpacks a framed, XOR-checksummed byte stream into 32-bit IROM writes
// and releases the CPU reset only after a frame has been accepted.
module irom_loader #(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  irom_loader_if.slave bus
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       asm_q, asm_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              irom_we_q, irom_we_d;
  logic [31:0]       irom_wadr_q, irom_wadr_d;
  logic [31:0]       irom_wdata_q, irom_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              active_s;
  logic              timeout_s;
  logic [15:0]       len_full_s;
  logic [16:0]       word_next_s;

  // Next-state, datapath and output computation for the frame parser.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    asm_d        = asm_q;
    gap_d        = gap_q;
    irom_we_d    = 1'b0;
    irom_wadr_d  = irom_wadr_q;
    irom_wdata_d = irom_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    len_full_s   = {bus.rx_data, len_q[7:0]};
    word_next_s  = {1'b0, word_idx_q} + 17'd1;

    active_s = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
               (state_q == ST_DATA) || (state_q == ST_CSUM);
    // An arriving byte always beats the expiry: timeout only fires on an idle cycle.
    timeout_s = active_s && !bus.rx_valid && (gap_q >= GAP_LAST);

    if (!active_s) begin
      gap_d = gap_q;
    end else if (bus.rx_valid) begin
      gap_d = {GAP_W{1'b0}};
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
          state_d    = ST_LEN0;
          load_err_d = 1'b0;
          len_d      = 16'd0;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
          csum_d     = 8'd0;
          asm_d      = 24'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN0: begin
        if (bus.rx_valid) begin
          len_d   = {8'd0, bus.rx_data};
          state_d = ST_LEN1;
        end else if (timeout_s) begin
          state_d    = ST_ERROR;
          load_err_d = 1'b1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (bus.rx_valid) begin
          len_d = len_full_s;
          if ({16'd0, len_full_s} > MAX_WORDS) begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
          end else if (len_full_s == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_s) begin
          state_d    = ST_ERROR;
          load_err_d = 1'b1;
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          csum_d = csum_step(csum_q, bus.rx_data);
          case (byte_idx_q)
            2'd0: begin
              asm_d[7:0] = bus.rx_data;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              asm_d[15:8] = bus.rx_data;
              byte_idx_d  = 2'd2;
            end
            2'd2: begin
              asm_d[23:16] = bus.rx_data;
              byte_idx_d   = 2'd3;
            end
            2'd3: begin
              irom_we_d    = 1'b1;
              irom_wdata_d = {bus.rx_data, asm_q};
              irom_wadr_d  = BASE_ADR + {14'd0, word_idx_q, 2'b00};
              word_idx_d   = word_next_s[15:0];
              byte_idx_d   = 2'd0;
              if (word_next_s == {1'b0, len_q}) begin
                state_d = ST_CSUM;
              end else begin
                state_d = ST_DATA;
              end
            end
            default: begin
              byte_idx_d = 2'd0;
            end
          endcase
        end else if (timeout_s) begin
          state_d    = ST_ERROR;
          load_err_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
          end
        end else if (timeout_s) begin
          state_d    = ST_ERROR;
          load_err_d = 1'b1;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_rst_n_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset holds the CPU in reset and parks at IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_idx_q   <= 2'd0;
      csum_q       <= 8'd0;
      asm_q        <= 24'd0;
      gap_q        <= {GAP_W{1'b0}};
      irom_we_q    <= 1'b0;
      irom_wadr_q  <= BASE_ADR;
      irom_wdata_q <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      asm_q        <= asm_d;
      gap_q        <= gap_d;
      irom_we_q    <= irom_we_d;
      irom_wadr_q  <= irom_wadr_d;
      irom_wdata_q <= irom_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.irom_we    = irom_we_q;
  assign bus.irom_wadr  = irom_wadr_q;
  assign bus.irom_wdata = irom_wdata_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: doc/irom_loader.md
Name: irom_loader

Overview:
- Boot-time program loader upstream of the pipelined CPU.
- Consumes a byte stream from a UART receiver, unpacks framed 32-bit instruction words and writes them into the IROM write port.
- Holds the CPU in reset until a complete frame with a valid checksum has been written.
- Frame format: MAGIC byte, 16-bit word count (LSB first), N words at 4 bytes each (LSB first), then 1 XOR-checksum byte over all payload bytes.

Parameters:
- MAGIC, 8'hA5, frame start byte.
- MAX_WORDS, 4096, largest accepted word count; IROM depth.
- BASE_ADR, 32'h0000_0000, byte address of the first word written.
- TIMEOUT, 100000, maximum idle cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  rx_data holds a new byte this cycle (single-cycle pulse per byte).
- rx_data  in  8  received byte.
- irom_we  out  1  IROM write strobe, one cycle per word.
- irom_wadr  out  32  IROM byte address, word aligned.
- irom_wdata  out  32  instruction word to write.
- cpu_rst_n  out  1  active-low reset to the cpu block.
- load_done  out  1  frame accepted; sticky.
- load_err  out  1  frame rejected; sticky until the next MAGIC.

Behaviour:
- Reset is asynchronous and active-low; the block runs on one clock, clk. Reset values: state=IDLE, irom_we=0, irom_wadr=BASE_ADR, irom_wdata=0, cpu_rst_n=0, load_done=0, load_err=0. All counters and the checksum are 0.
- Bytes are accepted only in cycles where rx_valid=1. There is no backpressure, so the loader must accept one byte every cycle.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- IDLE: a byte equal to MAGIC goes to LEN0. Any other byte is ignored.
- LEN0: latch len[7:0]; go to LEN1.
- LEN1: latch len[15:8].
  - len > MAX_WORDS: go to ERROR.
  - len == 0: go to CSUM.
  - Otherwise: go to DATA.
- Entering LEN0 clears word_idx, byte_idx and csum.
- DATA:
  - Each byte is shifted into an assembly register at bits [8*byte_idx +: 8].
  - csum ^= byte for every data byte.
  - On byte_idx == 3, in the next cycle: irom_we=1 for exactly one cycle, irom_wdata = assembled word, irom_wadr = BASE_ADR + 4*word_idx.
  - After that byte, word_idx increments and byte_idx wraps to 0.
  - When word_idx reaches len, go to CSUM.
- CSUM:
  - Byte == csum: go to DONE.
  - Otherwise: go to ERROR.
- DONE: load_done=1 and cpu_rst_n=1 from the cycle after the checksum byte. All further bytes are ignored until rst_n is asserted.
- ERROR: load_err=1 and cpu_rst_n stays 0. A MAGIC byte clears load_err and goes to LEN0; other bytes are ignored.
- Timeout:
  - A gap counter is cleared on every rx_valid and increments otherwise, only in LEN0, LEN1, DATA and CSUM.
  - When it reaches TIMEOUT, go to ERROR.
  - The counter saturates and is inactive in IDLE, DONE and ERROR.
- Words already written before an ERROR are not rolled back. cpu_rst_n is never released after an error.
- If rx_valid arrives in the same cycle as the timeout expiry, the byte wins: the counter clears and the FSM advances normally.
- rst_n asserted mid-frame returns the block to IDLE asynchronously. irom_we drops immediately and cpu_rst_n goes to 0.
- word_idx is 16 bits. irom_wadr is computed as a 32-bit sum, so there is no wrap within MAX_WORDS.
- irom_we is never asserted outside DATA.

Test Plan:
- Nominal load:
  - Stimulus: A5 02 00 13 00 00 00 93 00 10 00 followed by the checksum byte, which is the XOR of the 8 payload bytes = 8'h90.
  - Expected: two irom_we pulses, adr 0 with data 32'h0000_0013 and adr 4 with data 32'h0010_0093. Then load_done=1 and cpu_rst_n=1 one cycle after the checksum byte.
- Bad checksum:
  - Stimulus: the same frame with checksum 8'h91.
  - Expected: both words written, load_err=1, cpu_rst_n=0.
  - Follow-up: a correct full frame afterwards clears load_err on its MAGIC byte and ends with load_done=1.
- Zero-length frame:
  - Stimulus: A5 00 00 00.
  - Expected: no irom_we, load_done=1, cpu_rst_n=1.
  - Variant: A5 00 00 01 -> load_err=1.
- Oversize length and leading garbage:
  - Stimulus: 11 22 A5 01 10 (len=4097).
  - Expected: the leading bytes are ignored, ERROR is entered after the LEN1 byte, and irom_we never pulses.
- Timeout:
  - Stimulus: TIMEOUT=16; send A5 01 00 13, then idle 16 cycles.
  - Expected: load_err=1 and no irom_we.
  - Variant: a byte landing exactly on the expiry cycle -> no error.
- Mid-frame reset:
  - Stimulus: assert rst_n low during DATA, between bytes 2 and 3.
  - Expected: all outputs return to their reset values immediately. A fresh frame then loads correctly starting at BASE_ADR.
